// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display controller.
// Contents:
//   state_t    - conversion sequencer states (IDLE, SHIFT, LOAD)
//   SEG_BLANK  - active-low segment pattern with every segment off
//   DIG_BLANK  - BCD code stored in a digit register to mean "show nothing"
//   GLYPH_0..9 - active-low glyphs, bit0 = segment a .. bit6 = segment g
//   bcd_to_seg - maps one BCD code to its glyph; non-decimal codes go blank
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = GLYPH_0;
      4'd1:    seg = GLYPH_1;
      4'd2:    seg = GLYPH_2;
      4'd3:    seg = GLYPH_3;
      4'd4:    seg = GLYPH_4;
      4'd5:    seg = GLYPH_5;
      4'd6:    seg = GLYPH_6;
      4'd7:    seg = GLYPH_7;
      4'd8:    seg = GLYPH_8;
      4'd9:    seg = GLYPH_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Input handshake bundle of the display controller.
//   in_valid - source has a value on in_data
//   in_ready - controller can take a value this cycle
//   in_data  - unsigned binary value to display
//   blank_lz - travels with in_data; 1 = blank leading zeros
// master = value source, slave = display controller.
interface seg_display_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             blank_lz;

  modport master (output in_valid, output in_data, output blank_lz, input in_ready);
  modport slave  (input in_valid, input in_data, input blank_lz, output in_ready);
endinterface

// File: rtl/bcd7seg.sv
// One BCD to active-low seven-segment decoder.
// Ports:
//   bcd - digit code; 0-9 show a glyph, anything else is blank
//   seg - segments, bit0 = a .. bit6 = g, 0 = lit
module bcd7seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = bcd_to_seg(bcd);
endmodule

// File: rtl/bin2bcd_dd.sv
// Multi-cycle binary to BCD converter (double dabble, shift-add-3).
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   in_valid/in_ready  - input handshake, accepted only in IDLE
//   in_data            - binary value captured at the handshake
//   busy               - high in SHIFT and LOAD
//   bcd                - DIGITS packed BCD nibbles, digit 0 in bits [3:0]
//   bcd_valid          - high for the single LOAD cycle; bcd is final then
module bin2bcd_dd
  import seg_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  busy,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  bcd_valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               state;
  logic [WIDTH-1:0]     bin;
  logic [CW-1:0]        cnt;
  logic [DIGITS*4-1:0]  adj;

  // Add-3 correction before each shift. A nibble is at most 9 here, so the
  // sum stays within 4 bits and never carries into the next digit.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign in_ready = (state == IDLE) && !rst;

  // Sequencer: one bin bit moves into the BCD register per SHIFT cycle;
  // the last shift moves to LOAD, which flags the finished result for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin   <= in_data;
            bcd   <= '0;
            cnt   <= CW'(WIDTH - 1);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, bin} <= {adj, bin} << 1;
          if (cnt == '0) begin
            bcd_valid <= 1'b1;
            state     <= LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOAD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Display controller for a bank of BCD seven-segment digits.
// Takes a binary value over a valid/ready handshake, converts it to BCD,
// applies optional leading-zero blanking and drives one decoder per digit.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   in_if    - handshake bundle (in_valid, in_ready, in_data, blank_lz)
//   disp_en  - 0 turns every segment off without touching stored digits
//   busy     - a conversion is in progress
//   done     - one-cycle pulse in the cycle a new value is first shown
//   hex      - active-low segments, digit i at [7i+6:7i], digit 0 = LSD
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  seg_display_ctrl_if.slave   in_if,
  input  logic                disp_en,
  output logic                busy,
  output logic                done,
  output logic [DIGITS*7-1:0] hex
);

  // The BCD register has to hold the largest WIDTH-bit value.
  if (WIDTH * 30103 > DIGITS * 100000) begin : g_size_chk
    $error("seg_display_ctrl: DIGITS too small for WIDTH");
  end

  logic                 ready_w;
  logic [DIGITS*4-1:0]  bcd_w;
  logic                 bcd_valid_w;
  logic                 blank_q;
  logic                 lz_run;
  logic [DIGITS*4-1:0]  digit_d;
  logic [DIGITS*4-1:0]  digit_q;
  logic [DIGITS*7-1:0]  seg_w;

  bin2bcd_dd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_cvt (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_if.in_valid),
    .in_ready  (ready_w),
    .in_data   (in_if.in_data),
    .busy      (busy),
    .bcd       (bcd_w),
    .bcd_valid (bcd_valid_w)
  );

  assign in_if.in_ready = ready_w;

  // Blank zero digits from the top down until the first non-zero digit.
  // Digit 0 is left alone so a value of zero still shows "0".
  always_comb begin
    digit_d = bcd_w;
    lz_run  = blank_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lz_run && (bcd_w[4*i +: 4] == 4'd0)) begin
        digit_d[4*i +: 4] = DIG_BLANK;
      end else begin
        lz_run = 1'b0;
      end
    end
  end

  // blank_lz is captured with the value; digits only change when a result is
  // ready, so the old value stays on the display during a conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= 1'b0;
      digit_q <= {DIGITS{DIG_BLANK}};
      done    <= 1'b0;
    end else begin
      done <= bcd_valid_w;
      if (in_if.in_valid && ready_w) begin
        blank_q <= in_if.blank_lz;
      end
      if (bcd_valid_w) begin
        digit_q <= digit_d;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd7seg u_dec (
      .bcd (digit_q[4*g +: 4]),
      .seg (seg_w[7*g +: 7])
    );
  end

  assign hex = disp_en ? seg_w : {(DIGITS*7){1'b1}};

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl (WIDTH=16, DIGITS=5).
// Expected displays come from a decimal reference model and are queued when a
// value is driven; they are popped and compared whenever the DUT pulses done.
module tb_seg_display_ctrl;

  localparam int WIDTH   = 16;
  localparam int DIGITS  = 5;
  localparam int LATENCY = WIDTH + 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                disp_en;
  logic                busy;
  logic                done;
  logic [DIGITS*7-1:0] hex;

  int checkCount = 0;
  int passCount  = 0;
  int cyc        = 0;
  int doneCount  = 0;

  logic [DIGITS*7-1:0] expQ [$];
  int                  accPend [$];
  int                  accLog [$];

  seg_display_ctrl_if #(.WIDTH(WIDTH)) dut_if ();

  seg_display_ctrl #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_if   (dut_if),
    .disp_en (disp_en),
    .busy    (busy),
    .done    (done),
    .hex     (hex)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [DIGITS*7-1:0] expectedHex(input int unsigned value,
                                                       input logic blank);
    logic [3:0]          d [DIGITS];
    logic                lead;
    logic [DIGITS*7-1:0] r;
    int unsigned         v;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = 4'(v % 10);
      v    = v / 10;
    end
    lead = blank;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && d[i] == 4'd0) d[i] = 4'hF;
      else lead = 1'b0;
    end
    for (int i = 0; i < DIGITS; i++) r[7*i +: 7] = glyph(d[i]);
    return r;
  endfunction

  // Scoreboard: outputs sampled on the falling edge; inputs only change just
  // after rising edges, so what is seen here is what the next rising edge uses.
  always @(negedge clk) begin
    if (rst) begin
      accPend.delete();
    end else begin
      if (done) begin
        doneCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 64'd1, 64'd0);
        end else begin
          checkOutput("hex_on_done", 64'(hex), 64'(expQ.pop_front()));
        end
        if (accPend.size() != 0) begin
          checkOutput("done_latency", 64'(cyc - accPend.pop_front()), 64'(LATENCY));
        end
      end
      if (dut_if.in_valid && dut_if.in_ready) begin
        accPend.push_back(cyc);
        accLog.push_back(cyc);
      end
    end
  end

  task automatic nextCycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitReady();
    int waited = 0;
    while (!dut_if.in_ready && waited < 100) begin
      nextCycle(1);
      waited++;
    end
    if (!dut_if.in_ready) checkOutput("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic applyStimulus(input int unsigned value, input logic blank);
    waitReady();
    dut_if.in_valid = 1'b1;
    dut_if.in_data  = WIDTH'(value);
    dut_if.blank_lz = blank;
    expQ.push_back(expectedHex(value, blank));
    nextCycle(1);
    dut_if.in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int waited = 0;
    while (expQ.size() != 0 && waited < 100) begin
      nextCycle(1);
      waited++;
    end
    if (expQ.size() != 0) begin
      checkOutput("done_timeout", 64'(expQ.size()), 64'd0);
      expQ.delete();
    end
  endtask

  initial begin
    int held;
    int dc;

    rst             = 1'b1;
    disp_en         = 1'b1;
    dut_if.in_valid = 1'b0;
    dut_if.in_data  = '0;
    dut_if.blank_lz = 1'b0;

    // Reset for three cycles
    nextCycle(3);
    checkOutput("rst_hex", 64'(hex), 64'(35'h7_FFFF_FFFF));
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_ready", 64'(dut_if.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", 64'(dut_if.in_ready), 64'd1);
    nextCycle(1);

    // 1234 with blanking
    applyStimulus(1234, 1'b1);
    checkOutput("busy_in_shift", 64'(busy), 64'd1);
    checkOutput("ready_in_shift", 64'(dut_if.in_ready), 64'd0);
    waitIdle();
    checkOutput("1234_hex4", 64'(hex[34:28]), 64'(7'b1111111));
    checkOutput("1234_hex3", 64'(hex[27:21]), 64'(7'b1111001));
    checkOutput("1234_hex0", 64'(hex[6:0]), 64'(7'b0011001));

    // Zero, blanked and unblanked
    applyStimulus(0, 1'b1);
    waitIdle();
    checkOutput("zero_blank_hex0", 64'(hex[6:0]), 64'(7'b1000000));
    applyStimulus(0, 1'b0);
    waitIdle();

    // Full scale, then a single digit with leading zeros shown
    applyStimulus(65535, 1'b0);
    waitIdle();
    checkOutput("max_hex4", 64'(hex[34:28]), 64'(7'b0000010));
    checkOutput("max_hex0", 64'(hex[6:0]), 64'(7'b0010010));
    applyStimulus(9, 1'b0);
    waitIdle();

    // disp_en gates segments without losing the stored value
    disp_en = 1'b0;
    #1;
    checkOutput("disp_off", 64'(hex), 64'(35'h7_FFFF_FFFF));
    disp_en = 1'b1;
    #1;
    checkOutput("disp_on", 64'(hex), 64'(expectedHex(9, 1'b0)));
    nextCycle(1);

    // in_valid held high: two accepts, changes while busy ignored
    waitReady();
    dut_if.in_valid = 1'b1;
    dut_if.in_data  = 16'd100;
    dut_if.blank_lz = 1'b1;
    expQ.push_back(expectedHex(100, 1'b1));
    nextCycle(1);
    dut_if.in_data  = 16'd777;
    dut_if.blank_lz = 1'b0;
    nextCycle(5);
    dut_if.in_data  = 16'd200;
    expQ.push_back(expectedHex(200, 1'b0));
    held = 0;
    while (expQ.size() > 1 && held < 60) begin
      nextCycle(1);
      held++;
    end
    dut_if.in_valid = 1'b0;
    nextCycle(8);
    checkOutput("hold_busy", 64'(busy), 64'd1);
    checkOutput("hold_hex", 64'(hex), 64'(expectedHex(100, 1'b1)));
    waitIdle();
    if (accLog.size() >= 2) begin
      checkOutput("accept_spacing", 64'(accLog[accLog.size()-1] - accLog[accLog.size()-2]),
                  64'(LATENCY));
    end else begin
      checkOutput("accept_count", 64'(accLog.size()), 64'd2);
    end

    // Reset in the middle of a conversion
    applyStimulus(5555, 1'b0);
    void'(expQ.pop_back());
    nextCycle(7);
    dc  = doneCount;
    rst = 1'b1;
    nextCycle(1);
    checkOutput("abort_hex", 64'(hex), 64'(35'h7_FFFF_FFFF));
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("abort_ready", 64'(dut_if.in_ready), 64'd1);
    nextCycle(25);
    checkOutput("abort_no_done", 64'(doneCount), 64'(dc));
    applyStimulus(42, 1'b1);
    waitIdle();

    nextCycle(2);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
